dm_cache_ctrl: RTL and testbench

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

---
 rtl/cache_pkg.sv | 14 +
 rtl/cache_array.sv | 48 ++++
 rtl/dm_cache_ctrl.sv | 122 ++++++++++++
 tb/tb_dm_cache_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache controller.
package cache_pkg;
  localparam int LINES = 16;
  localparam int WORDS = 4;
  localparam int TAG_W = 10;
  localparam int IDX_W = 4;
  localparam int OFF_W = 2;

  typedef enum logic [1:0] {IDLE, LOOKUP, WB, RF} state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/cache_array.sv
// Line storage: data words, tags, valid/dirty bits. One combinational read port,
// one word write port that also refreshes the line's tag/valid/dirty.
module cache_array #(
  parameter int LINES = cache_pkg::LINES,
  parameter int WORDS = cache_pkg::WORDS
) (
  input  logic                      clk,
  input  logic                      inv_all_i,
  input  logic [cache_pkg::IDX_W-1:0] rd_idx_i,
  input  logic [cache_pkg::OFF_W-1:0] rd_off_i,
  output logic [31:0]               rd_data_o,
  output logic [cache_pkg::TAG_W-1:0] rd_tag_o,
  output logic                      rd_valid_o,
  output logic                      rd_dirty_o,
  input  logic                      wr_en_i,
  input  logic [cache_pkg::IDX_W-1:0] wr_idx_i,
  input  logic [cache_pkg::OFF_W-1:0] wr_off_i,
  input  logic [31:0]               wr_data_i,
  input  logic [cache_pkg::TAG_W-1:0] wr_tag_i,
  input  logic                      wr_dirty_i
);
  logic [31:0]               data_q [LINES][WORDS];
  logic [cache_pkg::TAG_W-1:0] tag_q [LINES];
  logic [LINES-1:0]          valid_q, dirty_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i][wr_off_i] <= wr_data_i;
      tag_q[wr_idx_i]            <= wr_tag_i;
    end
  end

  // Invalidate-all wins over a concurrent write so reset always leaves every line empty.
  always_ff @(posedge clk) begin
    if (inv_all_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= wr_dirty_i;
    end
  end

  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with hit/miss counters.
module dm_cache_ctrl #(
  parameter int LINES = cache_pkg::LINES,
  parameter int WORDS = cache_pkg::WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  import cache_pkg::*;

  state_e      state_q;
  logic        we_q, refill_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  k_q;
  logic [15:0] hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0] tag, rd_tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off, rd_off, wr_off;
  logic [31:0]      rd_data, wr_data;
  logic             rd_valid, rd_dirty, hit, wr_en;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^cpu_addr[31:16];

  assign tag = addr_q[15:6];
  assign idx = addr_q[5:2];
  assign off = addr_q[1:0];

  assign hit    = (state_q == LOOKUP) && rd_valid && (rd_tag == tag);
  assign rd_off = (state_q == WB) ? k_q[1:0] : off;
  // Refill data lags the read strobe by one cycle, so cycle k stores word k-1.
  assign wr_en   = !rst && ((hit && we_q) || (state_q == RF && k_q != 3'd0));
  assign wr_off  = (state_q == RF) ? k_q[1:0] - 2'd1 : off;
  assign wr_data = (state_q == RF) ? mem_dout : wdata_q;

  cache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk       (clk),
    .inv_all_i (rst),
    .rd_idx_i  (idx),
    .rd_off_i  (rd_off),
    .rd_data_o (rd_data),
    .rd_tag_o  (rd_tag),
    .rd_valid_o(rd_valid),
    .rd_dirty_o(rd_dirty),
    .wr_en_i   (wr_en),
    .wr_idx_i  (idx),
    .wr_off_i  (wr_off),
    .wr_data_i (wr_data),
    .wr_tag_i  (tag),
    .wr_dirty_i(state_q == LOOKUP)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      k_q        <= '0;
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_req) begin
          we_q     <= cpu_we;
          addr_q   <= cpu_addr[15:0];
          wdata_q  <= cpu_wdata;
          refill_q <= 1'b0;
          state_q  <= LOOKUP;
        end
        LOOKUP: begin
          // The lookup replayed after a refill belongs to the miss already counted.
          if (hit) begin
            if (!refill_q) hit_cnt_q <= sat_inc(hit_cnt_q);
            state_q <= IDLE;
          end else begin
            if (!refill_q) miss_cnt_q <= sat_inc(miss_cnt_q);
            k_q     <= '0;
            state_q <= (rd_valid && rd_dirty) ? WB : RF;
          end
        end
        WB: if (k_q == 3'd3) begin
          k_q     <= '0;
          state_q <= RF;
        end else k_q <= k_q + 3'd1;
        RF: if (k_q == 3'd4) begin
          k_q      <= '0;
          refill_q <= 1'b1;
          state_q  <= LOOKUP;
        end else k_q <= k_q + 3'd1;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; gating with rst keeps memory quiet during reset.
  assign cpu_ready = !rst && hit;
  assign cpu_rdata = cpu_ready ? rd_data : '0;
  assign mem_wen   = !rst && (state_q == WB);
  assign mem_ren   = !rst && (state_q == RF) && !k_q[2];
  assign mem_addr  = mem_wen ? {16'h0, rd_tag, idx, k_q[1:0]} :
                     mem_ren ? {16'h0, tag, idx, k_q[1:0]} : '0;
  assign mem_din   = mem_wen ? rd_data : '0;
  assign hit_cnt   = rst ? '0 : hit_cnt_q;
  assign miss_cnt  = rst ? '0 : miss_cnt_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Random and directed traffic against a flat-memory reference plus per-line tag model.
module tb_dm_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, mem_addr, mem_din;
  logic [31:0] mem_dout = '0, dout_nxt = '0;
  logic        cpu_ready, mem_ren, mem_wen;
  logic [15:0] hit_cnt, miss_cnt;

  int n_chk = 0, n_pass = 0;

  dm_cache_ctrl #(.LINES(16), .WORDS(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
  endtask

  // Memory: word[i] = i unless overwritten; overrides vanish on reset (memory reinitialises).
  logic [31:0] mem_wr [int];
  logic [15:0] rd_log [$];
  logic [47:0] wr_log [$];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mem_wr.exists(int'(a)) ? mem_wr[int'(a)] : {16'h0, a};
  endfunction

  always @(negedge clk) begin
    if (mem_wen) begin
      mem_wr[int'(mem_addr[15:0])] = mem_din;
      wr_log.push_back({mem_addr[15:0], mem_din});
    end
    if (mem_ren) rd_log.push_back(mem_addr[15:0]);
    dout_nxt = mem_ren ? mem_rd(mem_addr[15:0]) : 32'h0;
  end
  always @(posedge clk) mem_dout <= dout_nxt;

  logic prev_rdy = 1'b0;
  always @(negedge clk) begin
    chk("mem_excl", 32'(mem_ren & mem_wen), 32'h0);
    chk("rdy_pulse", 32'(prev_rdy & cpu_ready), 32'h0);
    prev_rdy = cpu_ready;
    chk("addr_hi", 32'(mem_addr[31:16]), 32'h0);
    if (rst) chk("rst_quiet", 32'({mem_ren, mem_wen, cpu_ready}), 32'h0);
    if (!cpu_ready) chk("rdata_idle", cpu_rdata, 32'h0);
    if (!mem_ren && !mem_wen) chk("mem_idle", mem_addr | mem_din, 32'h0);
  end

  // Reference: architectural memory plus which tag each index holds and whether it is dirty.
  logic [31:0] arch [int];
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [9:0]  m_tag   [16];
  int          m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    arch.delete(); mem_wr.delete();
    m_hits = 0; m_misses = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1; cpu_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_hit_cnt", 32'(hit_cnt), 32'h0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after cpu_ready.
  task automatic access(input logic we, input logic [15:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = {16'h0, a}; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = $urandom; cpu_wdata = $urandom;
    lat = 0; rd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (cpu_ready) begin lat = n; rd = cpu_rdata; break; end
    end
    @(negedge clk);
  endtask

  task automatic xact(input logic we, input logic [15:0] a, input logic [31:0] wd);
    int          ix, lat, exp_lat;
    logic [9:0]  tg;
    logic        is_hit;
    logic [31:0] rd, exp_rd;
    ix = int'(a[5:2]); tg = a[15:6];
    is_hit  = m_valid[ix] && (m_tag[ix] == tg);
    exp_lat = is_hit ? 1 : (m_valid[ix] && m_dirty[ix]) ? 11 : 7;
    exp_rd  = arch.exists(int'(a)) ? arch[int'(a)] : {16'h0, a};
    if (is_hit) m_hits++; else m_misses++;
    m_dirty[ix] = we ? 1'b1 : (is_hit ? m_dirty[ix] : 1'b0);
    m_valid[ix] = 1'b1; m_tag[ix] = tg;
    if (we) arch[int'(a)] = wd;
    access(we, a, wd, lat, rd);
    chk($sformatf("lat_%h", a), 32'(lat), 32'(exp_lat));
    if (!we) chk($sformatf("rdata_%h", a), rd, exp_rd);
  endtask

  logic [15:0] seq_addr [16];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Cold read miss, then a hit in the same line.
    rd_log.delete();
    xact(1'b0, 16'h0005, '0);
    chk("s40_rd_n", 32'(rd_log.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < rd_log.size()) chk("s40_rd_addr", 32'(rd_log[k]), 32'(4 + k));
    chk("s40_miss", 32'(miss_cnt), 32'd1);
    xact(1'b0, 16'h0006, '0);
    chk("s41_hit", 32'(hit_cnt), 32'd1);

    // Dirty the line, then evict it with a conflicting tag.
    xact(1'b1, 16'h0005, 32'hDEAD);
    rd_log.delete(); wr_log.delete();
    xact(1'b0, 16'h0045, '0);
    chk("s42_wb_n", 32'(wr_log.size()), 32'd4);
    if (wr_log.size() == 4) begin
      chk("s42_wb0", wr_log[0][31:0], 32'h4);    chk("s42_wa0", 32'(wr_log[0][47:32]), 32'h4);
      chk("s42_wb1", wr_log[1][31:0], 32'hDEAD); chk("s42_wa1", 32'(wr_log[1][47:32]), 32'h5);
      chk("s42_wb2", wr_log[2][31:0], 32'h6);    chk("s42_wb3", wr_log[3][31:0], 32'h7);
    end
    chk("s42_rf_n", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) chk("s42_rf0", 32'(rd_log[0]), 32'h44);

    // Reset during refill cycle 2.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h85;
    @(posedge clk); #1 cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    chk("s43_rf2_ren", 32'(mem_ren), 32'h1);
    chk("s43_rf2_addr", mem_addr, 32'h86);
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("s43_quiet", 32'({mem_ren, mem_wen}), 32'h0);
    end
    xact(1'b0, 16'h0005, '0);
    chk("s43_miss", 32'(miss_cnt), 32'd1);

    // Sweep every index twice, back to back.
    do_reset();
    for (int i = 0; i < 16; i++)
      seq_addr[i] = {10'($urandom_range(0, 1023)), 4'(i), 2'($urandom_range(0, 3))};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++) xact(1'b0, seq_addr[i], '0);
    chk("s44_hits", 32'(hit_cnt), 32'd16);
    chk("s44_misses", 32'(miss_cnt), 32'd16);

    // Random mix concentrated on a few indices and tags to force evictions.
    for (int i = 0; i < 80; i++)
      xact(1'($urandom_range(0, 1)),
           {10'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
           $urandom);
    chk("rand_hits", 32'(hit_cnt), 32'(m_hits));
    chk("rand_misses", 32'(miss_cnt), 32'(m_misses));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
